// File: rtl/i2c_cfg_pkg.sv
// Shared definitions for the I2C clock-device configuration sequencer:
// engine command codes, sequencer states and table entry layout.
package i2c_cfg_pkg;

  localparam logic [1:0] CMD_START = 2'd0;
  localparam logic [1:0] CMD_WRITE = 2'd1;
  localparam logic [1:0] CMD_STOP  = 2'd2;

  // Table entry: {reg_addr, reg_data}
  localparam int ENT_REG_MSB  = 15;
  localparam int ENT_REG_LSB  = 8;
  localparam int ENT_DATA_MSB = 7;
  localparam int ENT_DATA_LSB = 0;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_FETCH,
    ST_LOAD,
    ST_START,
    ST_DEV,
    ST_REG,
    ST_DATA,
    ST_STOP,
    ST_NEXT,
    ST_FINISH
  } seq_state_e;

  function automatic logic [7:0] dev_wr_byte(input logic [6:0] addr);
    return {addr, 1'b0};
  endfunction

endpackage

// File: rtl/i2c_cfg_rom.sv
// Synchronous register-table ROM (1-cycle read latency) feeding the sequencer.
// Entry i occupies INIT[16*i +: 16]; out-of-range reads return zero.
module i2c_cfg_rom #(
  parameter int                    ENTRIES = 16,
  parameter int                    IDX_W   = 4,
  parameter logic [ENTRIES*16-1:0] INIT    = '0
) (
  input  logic             clk_clk,
  input  logic             reset_reset_n,
  input  logic [IDX_W-1:0] addr,
  output logic [15:0]      data
);

  logic [15:0] data_q, data_d;

  always_comb begin
    data_d = 16'h0000;
    if (int'(addr) < ENTRIES) data_d = INIT[int'(addr)*16 +: 16];
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) data_q <= 16'h0000;
    else                data_q <= data_d;
  end

  assign data = data_q;

endmodule

// File: rtl/i2c_cfg_sequencer.sv
// Walks the register table and programs the clock device through a byte-level
// I2C engine: START / dev addr / reg / data / STOP per entry, with NACK retries.
module i2c_cfg_sequencer
  import i2c_cfg_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR  = 7'h6A,
  parameter int         ENTRIES   = 16,
  parameter int         IDX_W     = 4,
  parameter int         MAX_RETRY = 3
) (
  input  logic             clk_clk,
  input  logic             reset_reset_n,
  input  logic             start,
  output logic [IDX_W-1:0] tbl_addr,
  input  logic [15:0]      tbl_data,
  output logic             cmd_valid,
  input  logic             cmd_ready,
  output logic [1:0]       cmd_code,
  output logic [7:0]       cmd_data,
  input  logic             rsp_valid,
  input  logic             rsp_ack,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [IDX_W-1:0] err_index,
  output logic             irq
);

  localparam int               RTY_W    = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ENTRIES - 1);
  localparam logic [RTY_W-1:0] RTY_MAX  = RTY_W'(MAX_RETRY);

  seq_state_e       state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [RTY_W-1:0] retry_q, retry_d;
  logic             nack_q, nack_d;
  logic             rsp_wait_q, rsp_wait_d;
  logic [7:0]       reg_q, reg_d;
  logic [7:0]       data_q, data_d;
  logic [IDX_W-1:0] tbl_addr_q, tbl_addr_d;
  logic             cmd_valid_q, cmd_valid_d;
  logic [1:0]       cmd_code_q, cmd_code_d;
  logic [7:0]       cmd_data_q, cmd_data_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic [IDX_W-1:0] err_index_q, err_index_d;
  logic             irq_q, irq_d;

  // Command issue request, applied after the state decode.
  logic             issue_en;
  seq_state_e       issue_st;
  logic [1:0]       issue_code;
  logic [7:0]       issue_data;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    retry_d     = retry_q;
    nack_d      = nack_q;
    rsp_wait_d  = rsp_wait_q;
    reg_d       = reg_q;
    data_d      = data_q;
    tbl_addr_d  = tbl_addr_q;
    cmd_valid_d = cmd_valid_q;
    cmd_code_d  = cmd_code_q;
    cmd_data_d  = cmd_data_q;
    done_d      = done_q;
    err_d       = err_q;
    err_index_d = err_index_q;
    irq_d       = 1'b0;
    issue_en    = 1'b0;
    issue_st    = ST_START;
    issue_code  = CMD_START;
    issue_data  = 8'h00;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          done_d     = 1'b0;
          err_d      = 1'b0;
          idx_d      = '0;
          retry_d    = '0;
          tbl_addr_d = '0;
          state_d    = ST_FETCH;
        end
      end
      ST_FETCH: state_d = ST_LOAD;
      ST_LOAD: begin
        reg_d    = tbl_data[ENT_REG_MSB:ENT_REG_LSB];
        data_d   = tbl_data[ENT_DATA_MSB:ENT_DATA_LSB];
        nack_d   = 1'b0;
        issue_en = 1'b1;
      end
      ST_START, ST_DEV, ST_REG, ST_DATA, ST_STOP: begin
        if (cmd_valid_q) begin
          if (cmd_ready) begin
            cmd_valid_d = 1'b0;
            rsp_wait_d  = 1'b1;
          end
        end else if (rsp_wait_q && rsp_valid) begin
          rsp_wait_d = 1'b0;
          case (state_q)
            ST_START: begin
              issue_en   = 1'b1;
              issue_st   = ST_DEV;
              issue_code = CMD_WRITE;
              issue_data = dev_wr_byte(DEV_ADDR);
            end
            ST_DEV, ST_REG: begin
              issue_en = 1'b1;
              if (!rsp_ack) begin
                nack_d     = 1'b1;
                issue_st   = ST_STOP;
                issue_code = CMD_STOP;
              end else begin
                issue_st   = (state_q == ST_DEV) ? ST_REG : ST_DATA;
                issue_code = CMD_WRITE;
                issue_data = (state_q == ST_DEV) ? reg_q : data_q;
              end
            end
            ST_DATA: begin
              nack_d     = !rsp_ack;
              issue_en   = 1'b1;
              issue_st   = ST_STOP;
              issue_code = CMD_STOP;
            end
            default: begin
              // STOP completed: entry done, replay it, or give up
              if (!nack_q) begin
                state_d = ST_NEXT;
              end else if (retry_q < RTY_MAX) begin
                retry_d  = retry_q + 1'b1;
                nack_d   = 1'b0;
                issue_en = 1'b1;
              end else begin
                err_d       = 1'b1;
                err_index_d = idx_q;
                irq_d       = 1'b1;
                state_d     = ST_IDLE;
              end
            end
          endcase
        end
      end
      ST_NEXT: begin
        if (idx_q == LAST_IDX) begin
          done_d  = 1'b1;
          irq_d   = 1'b1;
          state_d = ST_FINISH;
        end else begin
          idx_d      = idx_q + 1'b1;
          tbl_addr_d = idx_q + 1'b1;
          retry_d    = '0;
          state_d    = ST_FETCH;
        end
      end
      ST_FINISH: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase

    if (issue_en) begin
      state_d     = issue_st;
      cmd_valid_d = 1'b1;
      cmd_code_d  = issue_code;
      cmd_data_d  = issue_data;
    end

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      retry_q     <= '0;
      nack_q      <= 1'b0;
      rsp_wait_q  <= 1'b0;
      reg_q       <= 8'h00;
      data_q      <= 8'h00;
      tbl_addr_q  <= '0;
      cmd_valid_q <= 1'b0;
      cmd_code_q  <= CMD_START;
      cmd_data_q  <= 8'h00;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      err_index_q <= '0;
      irq_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      retry_q     <= retry_d;
      nack_q      <= nack_d;
      rsp_wait_q  <= rsp_wait_d;
      reg_q       <= reg_d;
      data_q      <= data_d;
      tbl_addr_q  <= tbl_addr_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_code_q  <= cmd_code_d;
      cmd_data_q  <= cmd_data_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
      err_index_q <= err_index_d;
      irq_q       <= irq_d;
    end
  end

  assign tbl_addr  = tbl_addr_q;
  assign cmd_valid = cmd_valid_q;
  assign cmd_code  = cmd_code_q;
  assign cmd_data  = cmd_data_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign err_index = err_index_q;
  assign irq       = irq_q;

endmodule
